// File: rtl/phase_a.sv
// -----------------------------------------------------------------------------
// phase_a
// One Montgomery digit-reduction step on an N-bit operand:
//   q     = (a mod 2^DIGIT_W) * m_prime mod 2^DIGIT_W
//   new_a = (a + q*m) / 2^DIGIT_W, followed by one conditional subtraction of m
//           (done by adding m_n = 2^(N+2) - m and testing the top bit).
// q*m is accumulated one CHUNK_W-wide slice of m per clock.
//
// Ports
//   clk      in   1         rising-edge clock
//   rst_n    in   1         synchronous reset, ACTIVE-HIGH (1 = reset); the
//                           name is kept for compatibility with existing code
//   a        in   N         operand to reduce, sampled with en
//   m        in   N         modulus, sampled with en
//   m_n      in   N+2       2^(N+2) - m, sampled with en
//   m_prime  in   DIGIT_W   -m^-1 mod 2^DIGIT_W, sampled with en
//   en       in   1         start strobe (ignored unless idle)
//   new_a    out  N         result register, held until the next result/reset
//   en_out   out  1         one-cycle result-valid pulse
//   busy     out  1         only with PHASE_A_BUSY_EN: high while a step runs
//
// Build option
//   PHASE_A_BUSY_EN  when defined, adds the busy output port.
// -----------------------------------------------------------------------------
module phase_a #(
    parameter int unsigned N       = 3072,
    parameter int unsigned DIGIT_W = 110,
    parameter int unsigned CHUNK_W = 128
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       a,
    input  logic [N-1:0]       m,
    input  logic [N+1:0]       m_n,
    input  logic [DIGIT_W-1:0] m_prime,
    input  logic               en,
    output logic [N-1:0]       new_a,
    output logic               en_out
`ifdef PHASE_A_BUSY_EN
    ,
    output logic               busy
`endif
);

    localparam int unsigned NCHUNK = N / CHUNK_W;
    localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned ACC_W  = N + DIGIT_W + 1;
    localparam int unsigned PROD_W = DIGIT_W + CHUNK_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_QCALC,
        S_MAC,
        S_FINAL
    } state_t;

    state_t             state_q;
    logic [ACC_W-1:0]   acc_q;
    logic [N-1:0]       m_q;
    logic [N+1:0]       mn_q;
    logic [DIGIT_W-1:0] mp_q;
    logic [DIGIT_W-1:0] q_q;
    logic [IDX_W-1:0]   idx_q;
    logic [N-1:0]       new_a_q;
    logic               en_out_q;
`ifdef PHASE_A_BUSY_EN
    logic               busy_q;
`endif

    // The latched copy of a lives in the low bits of acc, so q is taken from
    // acc instead of keeping a separate a register. The product is truncated
    // to DIGIT_W bits by the assignment width.
    logic [DIGIT_W-1:0] q_d;
    assign q_d = acc_q[DIGIT_W-1:0] * mp_q;

    logic [CHUNK_W-1:0] m_chunk;
    logic [PROD_W-1:0]  prod;
    logic [ACC_W-1:0]   addend;
    assign m_chunk = m_q[idx_q*CHUNK_W +: CHUNK_W];
    assign prod    = {{CHUNK_W{1'b0}}, q_q} * {{DIGIT_W{1'b0}}, m_chunk};
    assign addend  = {{(ACC_W-PROD_W){1'b0}}, prod} << (idx_q*CHUNK_W);

    // Final correction: s[N+2] set means t + 2^(N+2) - m overflowed, i.e. t >= m.
    logic [N:0]   t;
    logic [N+2:0] s;
    logic [1:0]   unused_s_mid;
    assign t            = acc_q[ACC_W-1:DIGIT_W];
    assign s            = {2'b00, t} + {1'b0, mn_q};
    assign unused_s_mid = s[N+1:N];

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            m_q      <= '0;
            mn_q     <= '0;
            mp_q     <= '0;
            q_q      <= '0;
            idx_q    <= '0;
            new_a_q  <= '0;
            en_out_q <= 1'b0;
`ifdef PHASE_A_BUSY_EN
            busy_q   <= 1'b0;
`endif
        end else begin
            en_out_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (en) begin
                        acc_q   <= {{(DIGIT_W+1){1'b0}}, a};
                        m_q     <= m;
                        mn_q    <= m_n;
                        mp_q    <= m_prime;
                        state_q <= S_QCALC;
`ifdef PHASE_A_BUSY_EN
                        busy_q  <= 1'b1;
`endif
                    end
                end
                S_QCALC: begin
                    q_q     <= q_d;
                    idx_q   <= '0;
                    state_q <= S_MAC;
                end
                S_MAC: begin
                    acc_q <= acc_q + addend;
                    if (idx_q == IDX_W'(NCHUNK - 1)) begin
                        state_q <= S_FINAL;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                S_FINAL: begin
                    new_a_q  <= s[N+2] ? s[N-1:0] : t[N-1:0];
                    en_out_q <= 1'b1;
                    state_q  <= S_IDLE;
`ifdef PHASE_A_BUSY_EN
                    busy_q   <= 1'b0;
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign new_a  = new_a_q;
    assign en_out = en_out_q;
`ifdef PHASE_A_BUSY_EN
    assign busy   = busy_q;
`endif

endmodule

// File: tb/tb_phase_a.sv
// -----------------------------------------------------------------------------
// tb_phase_a
// Directed self-checking bench for phase_a at default parameters. Latency is
// counted in clock edges with the edge that samples en as edge 1, so en_out is
// expected to be seen first after edge 27.
// Build option PHASE_A_BUSY_EN is honoured (busy port connected and checked).
// -----------------------------------------------------------------------------
module tb_phase_a;

    localparam int unsigned N  = 3072;
    localparam int unsigned DW = 110;
    localparam int unsigned CW = 128;
    localparam int unsigned LAT = N / CW + 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  a;
    logic [N-1:0]  m;
    logic [N+1:0]  m_n;
    logic [DW-1:0] m_prime;
    logic          en;
    logic [N-1:0]  new_a;
    logic          en_out;
`ifdef PHASE_A_BUSY_EN
    logic          busy;
`endif

    int n_vec = 0;
    int n_err = 0;

    phase_a #(.N(N), .DIGIT_W(DW), .CHUNK_W(CW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a),
        .m       (m),
        .m_n     (m_n),
        .m_prime (m_prime),
        .en      (en),
        .new_a   (new_a),
        .en_out  (en_out)
`ifdef PHASE_A_BUSY_EN
        ,
        .busy    (busy)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h (low 64 bits shown)",
                     tag, got[63:0], exp[63:0]);
        end
    endtask

    function automatic logic [N+1:0] mneg(input logic [N-1:0] mv);
        return ~{2'b00, mv} + 1'b1;
    endfunction

    // Whole-operand reference of the reduction equations (no chunking).
    function automatic logic [N-1:0] model(input logic [N-1:0] av, input logic [N-1:0] mv,
                                           input logic [DW-1:0] mpv);
        logic [DW-1:0]   q;
        logic [N+DW:0]   acc;
        logic [N:0]      t;
        logic [N+2:0]    s;
        q   = av[DW-1:0] * mpv;
        acc = {{(DW+1){1'b0}}, av} + ({{(N+1){1'b0}}, q} * {{(DW+1){1'b0}}, mv});
        t   = acc[N+DW:DW];
        s   = {2'b00, t} + {1'b0, mneg(mv)};
        return s[N+2] ? s[N-1:0] : t[N-1:0];
    endfunction

    function automatic logic [N-1:0] rand_wide();
        logic [N-1:0] v;
        for (int unsigned w = 0; w < N / 32; w++) v[w*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic pulse_en(input logic [N-1:0] va, input logic [N-1:0] vm,
                            input logic [DW-1:0] vmp);
        @(negedge clk);
        a = va; m = vm; m_n = mneg(vm); m_prime = vmp; en = 1'b1;
        @(posedge clk);
    endtask

    task automatic run_step(input string tag, input logic [N-1:0] va, input logic [N-1:0] vm,
                            input logic [DW-1:0] vmp, input logic [N-1:0] exp);
        int lat;
        bit seen;
        pulse_en(va, vm, vmp);
        #1;
`ifdef PHASE_A_BUSY_EN
        check({tag, ".busy_rise"}, N'(busy), N'(1));
`endif
        @(negedge clk);
        en = 1'b0;
        // Inputs are scrambled after the start edge; only latched copies count.
        a = ~va; m = ~vm; m_n = '1; m_prime = ~vmp;
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat < 60) begin
            @(posedge clk); #1;
            lat++;
            if (en_out) seen = 1'b1;
        end
        check({tag, ".lat"}, N'(lat), N'(LAT));
        check({tag, ".new_a"}, new_a, exp);
`ifdef PHASE_A_BUSY_EN
        check({tag, ".busy_fall"}, N'(busy), N'(0));
`endif
        @(posedge clk); #1;
        check({tag, ".pulse_end"}, N'(en_out), N'(0));
        check({tag, ".hold"}, new_a, exp);
    endtask

    task automatic count_pulses(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (en_out) pulses++;
        end
    endtask

    initial begin
        logic [N-1:0]  va, vm, vexp;
        logic [DW-1:0] mp_fix;
        int            pulses;

        rst_n = 1'b1; en = 1'b0;
        a = '0; m = '0; m_n = '0; m_prime = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.new_a", new_a, '0);
        check("rst.en_out", N'(en_out), '0);
`ifdef PHASE_A_BUSY_EN
        check("rst.busy", N'(busy), '0);
`endif
        @(negedge clk);
        rst_n = 1'b0;

        // Hand-computed small vectors (m = 3, m_prime = 0 gives q = 0).
        run_step("zero", '0, N'(3), '0, '0);
        va = N'(5); va = va << DW;
        run_step("sub", va, N'(3), '0, N'(2));
        va = N'(3); va = va << DW;
        run_step("t_eq_m", va, N'(3), '0, '0);
        va = N'(2); va = va << DW;
        run_step("t_lt_m", va, N'(3), '0, N'(2));

        // m = 2^110-1, m_prime = 1.
        vm = '0; vm[DW-1:0] = '1;
        run_step("qpath", N'(1), vm, DW'(1), N'(1));
        // a = 2m-1: q = 2^110-3, acc = 2^220-2^111, t = 2^110-2 < m.
        va = vm + vm - 1'b1;
        vexp = vm - 1'b1;
        run_step("qbig", va, vm, DW'(1), vexp);

        // Full-width vectors against the whole-operand reference.
        mp_fix = 110'h2A5F3C198E7D0B4691C357E2D0AB;
        for (int k = 0; k < 4; k++) begin
            vm = rand_wide();
            vm[N-1] = 1'b1;
            vm[0]   = 1'b1;
            va = rand_wide();
            run_step($sformatf("wide%0d", k), va, vm, mp_fix, model(va, vm, mp_fix));
        end

        // en held high for three edges: only the first is accepted.
        vm = '0; vm[DW-1:0] = '1;
        @(negedge clk);
        a = N'(1); m = vm; m_n = mneg(vm); m_prime = DW'(1); en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        en = 1'b0;
        count_pulses(60, pulses);
        check("held.pulses", N'(pulses), N'(1));
        check("held.new_a", new_a, N'(1));

        // Reset during MAC aborts the step; no en_out follows.
        va = N'(5); va = va << DW;
        pulse_en(va, N'(3), '0);
        @(negedge clk);
        en = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        count_pulses(40, pulses);
        check("abort.pulses", N'(pulses), '0);
        check("abort.new_a", new_a, '0);
        run_step("post_rst", va, N'(3), '0, N'(2));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
